// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_REQ    = 2'd0,  // issue the bus request for pc
    S_WAIT   = 2'd1,  // address accepted, awaiting read data
    S_VALID  = 2'd2,  // instruction held in F
    S_CANCEL = 2'd3   // one stale response still to be discarded
  } fetch_state_t;

  // Boot vector, also where the exception unit sends the pipeline after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Holds a taken-branch target until its delay-slot instruction leaves F.
// Exception redirects always flush any pending branch target.
module fetch_redirect_buf
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic        redirect_pc_unused_guard,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_is_exc,
  input  logic        consume,
  output logic        take_valid,
  output logic [31:0] take_pc
);

  logic        pending_valid;
  logic [31:0] pending_pc;
  logic        branch_now;
  logic        exc_now;

  assign branch_now = redirect_valid & ~redirect_is_exc;
  assign exc_now    = redirect_valid & redirect_is_exc;

  // A branch arriving in the same cycle the delay slot is consumed bypasses the register.
  assign take_valid = pending_valid | branch_now;
  assign take_pc    = branch_now ? redirect_pc : pending_pc;

  // Pending-branch register: exception clears, consumption clears, branch sets.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pending_valid <= 1'b0;
      pending_pc    <= '0;
    end else if (exc_now || consume) begin
      pending_valid <= 1'b0;
    end else if (branch_now) begin
      pending_valid <= 1'b1;
      pending_pc    <= redirect_pc;
    end
  end

  logic unused_ok;
  assign unused_ok = redirect_pc_unused_guard;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the instruction bus handshake and
// presents the fetched instruction, its PC and delay-slot flag to F/D.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_is_exc,
  input  logic        is_branch_D,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic [31:0] instrF,
  output logic        instr_validF,
  output logic        F_change,
  output logic        fetch_stall,
  output logic        adelF
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  instr_q;
  logic         latch_instr;
  logic         exc_now;
  logic         misaligned;
  logic         consume;
  logic         take_valid;
  logic [31:0]  take_pc;

  assign exc_now    = redirect_valid & redirect_is_exc;
  assign misaligned = (pc[1:0] != 2'b00);
  assign consume    = (state == S_VALID) & ~stallF & ~exc_now;

  fetch_redirect_buf u_redirect_buf (
    .clk                      (clk),
    .rst                      (rst),
    .redirect_valid           (redirect_valid),
    .redirect_pc_unused_guard (1'b0),
    .redirect_pc              (redirect_pc),
    .redirect_is_exc          (redirect_is_exc),
    .consume                  (consume),
    .take_valid               (take_valid),
    .take_pc                  (take_pc)
  );

  // Next-state, next-pc and instruction-capture decisions.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_n     = state;
    pc_n        = pc;
    latch_instr = 1'b0;
    unique case (state)
      S_REQ: begin
        if (exc_now)           pc_n    = redirect_pc;
        else if (misaligned)   state_n = S_VALID;
        else if (inst_addr_ok) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (exc_now) begin
          pc_n    = redirect_pc;
          state_n = inst_data_ok ? S_REQ : S_CANCEL;
        end else if (inst_data_ok) begin
          latch_instr = 1'b1;
          state_n     = S_VALID;
        end
      end
      S_VALID: begin
        if (exc_now) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end else if (!stallF) begin
          pc_n    = take_valid ? take_pc : pc + 32'd4;
          state_n = S_REQ;
        end
      end
      S_CANCEL: begin
        if (exc_now)      pc_n    = redirect_pc;
        if (inst_data_ok) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      instr_q <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (latch_instr)                          instr_q <= inst_rdata;
      else if (state == S_REQ && state_n == S_VALID) instr_q <= '0;
    end
  end

  // The request is withheld during reset and when an exception retargets pc this cycle.
  assign inst_req     = (state == S_REQ) & ~misaligned & ~rst & ~exc_now;
  assign inst_addr    = pc;
  assign pcF          = pc;
  assign pc_plus4F    = pc + 32'd4;
  assign instr_validF = (state == S_VALID);
  assign instrF       = instr_validF ? instr_q : '0;
  assign fetch_stall  = ~instr_validF;
  assign adelF        = instr_validF & misaligned;
  assign F_change     = is_branch_D & ((state == S_VALID) | (state == S_WAIT)) & ~exc_now;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-outstanding instruction bus responder.
module tb_fetch_ctrl;

  localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_is_exc;
  logic        is_branch_D;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic [31:0] instrF;
  logic        instr_validF;
  logic        F_change;
  logic        fetch_stall;
  logic        adelF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallF          (stallF),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_is_exc (redirect_is_exc),
    .is_branch_D     (is_branch_D),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .pcF             (pcF),
    .pc_plus4F       (pc_plus4F),
    .instrF          (instrF),
    .instr_validF    (instr_validF),
    .F_change        (F_change),
    .fetch_stall     (fetch_stall),
    .adelF           (adelF)
  );

  // Bus responder: accepts when idle, returns addr^MAGIC after lat extra cycles.
  int          lat = 0;
  int          cnt = 0;
  logic        outst;
  logic [31:0] baddr;

  assign inst_addr_ok = inst_req && !outst;
  assign inst_data_ok = outst && (cnt == 0);
  assign inst_rdata   = inst_data_ok ? (baddr ^ MAGIC) : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      outst <= 1'b0;
    end else if (inst_data_ok) begin
      outst <= 1'b0;
    end else if (outst) begin
      cnt <= cnt - 1;
    end else if (inst_addr_ok) begin
      outst <= 1'b1;
      cnt   <= lat;
      baddr <= inst_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    redirect_is_exc = 1'b0; is_branch_D = 1'b0;
    @(posedge clk); @(posedge clk);
    step(); #1;
    check("rst_req",    {31'b0, inst_req},     32'd0);
    check("rst_valid",  {31'b0, instr_validF}, 32'd0);
    check("rst_instr",  instrF,                32'd0);
    check("rst_adel",   {31'b0, adelF},        32'd0);
    check("rst_pc",     pcF,                   32'hBFC0_0000);

    // Zero-wait sequential fetch.
    rst = 1'b0; #1;
    check("a0_req",  {31'b0, inst_req}, 32'd1);
    check("a0_addr", inst_addr,         32'hBFC0_0000);
    step(); #1;
    check("a0_wait_req",   {31'b0, inst_req},    32'd0);
    check("a0_wait_stall", {31'b0, fetch_stall}, 32'd1);
    step(); #1;
    check("a0_valid", {31'b0, instr_validF}, 32'd1);
    check("a0_instr", instrF,    32'hBFC0_0000 ^ MAGIC);
    check("a0_pc4",   pc_plus4F, 32'hBFC0_0004);
    step(); #1;
    check("a1_addr",  inst_addr,             32'hBFC0_0004);
    check("a1_valid", {31'b0, instr_validF}, 32'd0);
    step();
    step();
    // F holds BFC00004 (delay slot); branch in D redirects to 80001000 while stalled.
    stallF = 1'b1; is_branch_D = 1'b1;
    redirect_valid = 1'b1; redirect_is_exc = 1'b0; redirect_pc = 32'h8000_1000; #1;
    check("br_fchange", {31'b0, F_change}, 32'd1);
    check("br_pc",      pcF,               32'hBFC0_0004);
    step();
    redirect_valid = 1'b0; stallF = 1'b0; is_branch_D = 1'b0; #1;
    check("br_slot_valid", {31'b0, instr_validF}, 32'd1);
    check("br_slot_instr", instrF, 32'hBFC0_0004 ^ MAGIC);
    step();
    lat = 2; #1;
    check("br_target_addr", inst_addr,         32'h8000_1000);
    check("br_target_req",  {31'b0, inst_req}, 32'd1);

    // Exception in WAIT; stale data returns two cycles later.
    step();
    is_branch_D = 1'b1; redirect_valid = 1'b1; redirect_is_exc = 1'b1;
    redirect_pc = 32'hBFC0_0380; #1;
    check("exc_fchange", {31'b0, F_change}, 32'd0);
    check("exc_req",     {31'b0, inst_req}, 32'd0);
    step();
    redirect_valid = 1'b0; is_branch_D = 1'b0; #1;
    check("cancel_req",   {31'b0, inst_req},     32'd0);
    check("cancel_valid", {31'b0, instr_validF}, 32'd0);
    step(); #1;
    check("cancel_dok",     {31'b0, inst_data_ok}, 32'd1);
    check("cancel_hidden",  {31'b0, instr_validF}, 32'd0);
    check("cancel_req2",    {31'b0, inst_req},     32'd0);
    lat = 0;
    step(); #1;
    check("exc_target_addr", inst_addr,         32'hBFC0_0380);
    check("exc_target_req",  {31'b0, inst_req}, 32'd1);
    step();
    step();
    // Four stalled cycles in VALID.
    stallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_pc",    pcF,                   32'hBFC0_0380);
      check("stall_instr", instrF,                32'hBFC0_0380 ^ MAGIC);
      check("stall_req",   {31'b0, inst_req},     32'd0);
      check("stall_valid", {31'b0, instr_validF}, 32'd1);
      step();
    end
    stallF = 1'b0; #1;
    check("stall_end_valid", {31'b0, instr_validF}, 32'd1);
    step(); #1;
    check("stall_next_addr", inst_addr, 32'hBFC0_0384);

    // Branch then exception on the following cycle: branch target lost.
    step();
    step();
    stallF = 1'b1; redirect_valid = 1'b1; redirect_is_exc = 1'b0; redirect_pc = 32'h8000_2000;
    step();
    redirect_is_exc = 1'b1; redirect_pc = 32'h8000_3000;
    step();
    redirect_valid = 1'b0; stallF = 1'b0; #1;
    check("bx_addr", inst_addr, 32'h8000_3000);
    step();
    step(); #1;
    check("bx_pc", pcF, 32'h8000_3000);
    step(); #1;
    check("bx_no_branch", inst_addr, 32'h8000_3004);

    // Exception to a misaligned target.
    step();
    step();
    redirect_valid = 1'b1; redirect_is_exc = 1'b1; redirect_pc = 32'h8000_0002;
    step();
    redirect_valid = 1'b0; #1;
    check("mis_req", {31'b0, inst_req}, 32'd0);
    check("mis_pc",  pcF,               32'h8000_0002);
    step(); #1;
    check("mis_adel",  {31'b0, adelF},        32'd1);
    check("mis_instr", instrF,                32'd0);
    check("mis_valid", {31'b0, instr_validF}, 32'd1);
    check("mis_pcF",   pcF,                   32'h8000_0002);

    // pc_plus4F wraps at the top of the address space.
    redirect_valid = 1'b1; redirect_is_exc = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; #1;
    check("wrap_pc",  pcF,       32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4F, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage MIPS pipeline.
- Generates the fetch PC and drives the SRAM-like instruction bus handshake.
- Applies branch and exception redirects with MIPS delay-slot semantics.
- Presents pcF, pc_plus4F, instrF and the delay-slot flag F_change to the F/D pipeline register; asserts fetch_stall while no valid instruction is available.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
stallF  in  1  pipeline cannot accept a new instruction into D this cycle
redirect_valid  in  1  redirect request, one-cycle pulse
redirect_pc  in  32  redirect target
redirect_is_exc  in  1  1: exception/ERET flush (kill F); 0: taken branch/jump (keep delay slot)
is_branch_D  in  1  instruction currently in D is a branch/jump
inst_req  out  1  bus request
inst_addr  out  32  bus address
inst_addr_ok  in  1  address accepted
inst_data_ok  in  1  read data returned
inst_rdata  in  32  read data
pcF  out  32  PC of the instruction in F
pc_plus4F  out  32  pcF + 4
instrF  out  32  fetched instruction; 0 when not valid
instr_validF  out  1  instrF is valid
F_change  out  1  instruction in F is a delay slot
fetch_stall  out  1  ~instr_validF
adelF  out  1  pcF misaligned (fetch address error)

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=REQ, pc=RESET_PC, pending cleared, instrF=0, instr_validF=0, inst_req=0 during the reset cycle, adelF=0.
- States:
  - REQ: inst_req=1, inst_addr=pc. On inst_addr_ok go to WAIT. Not entered for a misaligned pc.
  - WAIT: await inst_data_ok.
  - VALID: instruction held in F.
  - CANCEL: discard one outstanding response.
- REQ with pc[1:0]!=0: no bus request; go directly to VALID with instrF=0 and adelF=1.
- WAIT with inst_data_ok: latch inst_rdata into instrF, go to VALID.
- VALID with ~stallF: instruction consumed at the edge. pc <= pending_pc if pending_valid (then clear pending), else pc+4. Go to REQ.
- VALID with stallF: hold all outputs.
- Minimum latency per instruction, with zero-wait bus: 3 cycles (REQ, WAIT, VALID).
- Branch redirect (redirect_is_exc=0): stores pending_valid=1 and pending_pc. The current F instruction (the delay slot) is kept, or still awaited if in flight. The target is applied when that instruction is consumed.
- Exception redirect (redirect_is_exc=1) clears pending, then by state:
  - REQ: pc <= target, stay in REQ; the address was not yet accepted.
  - WAIT without inst_data_ok: go to CANCEL.
  - WAIT with inst_data_ok same cycle: discard the data, go to REQ at the target.
  - VALID: drop the instruction, go to REQ at the target.
  - CANCEL: update pc only.
- CANCEL: on inst_data_ok discard the data, go to REQ with pc=target.
- Exception and pending branch together: the exception wins and the branch target is lost.
- F_change = is_branch_D & instr_validF-or-in-flight & ~(redirect_valid & redirect_is_exc).
- pc_plus4F is always pcF+4, with 32-bit wrap.
- Only one bus transaction is outstanding; inst_req is never asserted in WAIT or CANCEL.

Decomposition:
- Shared package holds the state encoding (REQ, WAIT, VALID, CANCEL) and the RESET_PC constant used by the exception unit.
- One sub-module is natural: fetch_redirect_buf, holding pending_valid/pending_pc and the exception-over-branch priority.

Test Plan:
- Reset, zero-wait bus, stallF=0 -> first inst_addr=BFC00000, then BFC00004, BFC00008; instr_validF high every 3rd cycle.
- Branch redirect to 80001000 while F holds BFC00004 -> BFC00004 issued to D with F_change=1; next inst_addr=80001000.
- Exception redirect to BFC00380 in WAIT, data_ok 2 cycles later -> returned data never visible (instr_validF=0); next inst_addr=BFC00380.
- Branch redirect followed next cycle by exception redirect -> exception target fetched; branch target never requested.
- stallF=1 for 4 cycles in VALID -> pcF/instrF stable, no inst_req; then continues with pc+4.
- Exception redirect to misaligned 80000002 -> no inst_req; adelF=1, instrF=0, pcF=80000002.
